// File: rtl/neopixel_frame_builder.sv
// rtl/neopixel_frame_builder.sv - shadow/live framebuf builder for the neopixel driver
// Optional per-channel brightness scaling under NEOPIXEL_BRIGHTNESS_EN.
module neopixel_frame_builder #(
    parameter int NUM_LEDS = 16,
    parameter int IDX_W    = 4
) (
    input  logic                    clk,
    input  logic                    nrst,
    input  logic                    wr_valid,
    output logic                    wr_ready,
    input  logic [IDX_W-1:0]        wr_idx,
    input  logic [23:0]             wr_rgb,
    input  logic                    clr_req,
    input  logic                    commit,
`ifdef NEOPIXEL_BRIGHTNESS_EN
    input  logic [7:0]              brightness,
`endif
    output logic                    busy,
    output logic [7:0]              frame_count,
    output logic                    idx_err,
    output logic [24*NUM_LEDS-1:0]  framebuf
);

    typedef enum logic {S_IDLE, S_FILL} state_t;

    state_t                 r_state;
    state_t                 w_state_nxt;
    logic [24*NUM_LEDS-1:0] r_shadow;
    logic [24*NUM_LEDS-1:0] r_framebuf;
    logic [23:0]            r_fill_grb;
    logic [IDX_W-1:0]       r_fill_idx;
    logic [7:0]             r_count;
    logic                   r_idx_err;
    logic                   r_pending;

    logic [7:0]             w_r;
    logic [7:0]             w_g;
    logic [7:0]             w_b;
    logic [23:0]            w_grb;
    logic                   w_wr_fire;
    logic                   w_idx_ok;
    logic                   w_fill_last;
    logic                   w_commit_exec;

`ifdef NEOPIXEL_BRIGHTNESS_EN
    function automatic logic [7:0] scale(input logic [7:0] c, input logic [7:0] b);
        logic [15:0] p;
        p = 16'(c) * 16'({1'b0, b} + 9'd1);
        return p[15:8];
    endfunction

    assign w_r = scale(wr_rgb[23:16], brightness);
    assign w_g = scale(wr_rgb[15:8],  brightness);
    assign w_b = scale(wr_rgb[7:0],   brightness);
`else
    assign w_r = wr_rgb[23:16];
    assign w_g = wr_rgb[15:8];
    assign w_b = wr_rgb[7:0];
`endif

    // Wire order per LED is G, R, B from the low byte up.
    assign w_grb         = {w_b, w_r, w_g};
    assign wr_ready      = nrst && (r_state == S_IDLE) && !clr_req;
    assign w_wr_fire     = wr_valid && wr_ready;
    assign w_idx_ok      = (32'(wr_idx) < NUM_LEDS);
    assign w_fill_last   = (32'(r_fill_idx) == NUM_LEDS - 1);
    assign w_commit_exec = r_pending && (r_state == S_IDLE);

    always_ff @(posedge clk) begin
        if (!nrst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (clr_req)     w_state_nxt = S_FILL;
            S_FILL:  if (w_fill_last) w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!nrst) begin
            r_shadow   <= '0;
            r_framebuf <= '0;
            r_fill_grb <= '0;
            r_fill_idx <= '0;
            r_count    <= '0;
            r_idx_err  <= 1'b0;
            r_pending  <= 1'b0;
        end else begin
            if (w_wr_fire) begin
                if (w_idx_ok) r_shadow[32'(wr_idx)*24 +: 24] <= w_grb;
                else          r_idx_err <= 1'b1;
            end
            if (r_state == S_IDLE && clr_req) begin
                r_fill_grb <= w_grb;
                r_fill_idx <= '0;
            end
            if (r_state == S_FILL) begin
                r_shadow[32'(r_fill_idx)*24 +: 24] <= r_fill_grb;
                r_fill_idx <= r_fill_idx + IDX_W'(1);
            end
            if (w_commit_exec) begin
                r_framebuf <= r_shadow;
                r_count    <= r_count + 8'd1;
            end
            // A commit arriving while one is pending folds into it.
            r_pending <= (r_pending && !w_commit_exec) || (commit && !r_pending);
        end
    end

    assign busy        = nrst && ((r_state == S_FILL) || r_pending);
    assign frame_count = r_count;
    assign idx_err     = r_idx_err;
    assign framebuf    = r_framebuf;

endmodule

// File: tb/tb_neopixel_frame_builder.sv
// tb/tb_neopixel_frame_builder.sv - directed self-checking bench for neopixel_frame_builder
module tb_neopixel_frame_builder;

    logic         clk = 1'b0;
    logic         nrst;
    logic         wr_valid, wr_ready, clr_req, commit, busy, idx_err;
    logic [3:0]   wr_idx;
    logic [23:0]  wr_rgb;
    logic [7:0]   frame_count;
    logic [383:0] framebuf;

    logic         s_wr_valid, s_wr_ready, s_clr_req, s_commit, s_busy, s_idx_err;
    logic [3:0]   s_wr_idx;
    logic [23:0]  s_wr_rgb;
    logic [7:0]   s_frame_count;
    logic [191:0] s_framebuf;
`ifdef NEOPIXEL_BRIGHTNESS_EN
    logic [7:0]   brightness = 8'd255;
`endif

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    neopixel_frame_builder #(.NUM_LEDS(16), .IDX_W(4)) u_dut (
        .clk(clk), .nrst(nrst), .wr_valid(wr_valid), .wr_ready(wr_ready),
        .wr_idx(wr_idx), .wr_rgb(wr_rgb), .clr_req(clr_req), .commit(commit),
`ifdef NEOPIXEL_BRIGHTNESS_EN
        .brightness(brightness),
`endif
        .busy(busy), .frame_count(frame_count), .idx_err(idx_err), .framebuf(framebuf)
    );

    neopixel_frame_builder #(.NUM_LEDS(8), .IDX_W(4)) u_dut8 (
        .clk(clk), .nrst(nrst), .wr_valid(s_wr_valid), .wr_ready(s_wr_ready),
        .wr_idx(s_wr_idx), .wr_rgb(s_wr_rgb), .clr_req(s_clr_req), .commit(s_commit),
`ifdef NEOPIXEL_BRIGHTNESS_EN
        .brightness(brightness),
`endif
        .busy(s_busy), .frame_count(s_frame_count), .idx_err(s_idx_err), .framebuf(s_framebuf)
    );

    task automatic check(input string tag, input logic [383:0] got, input logic [383:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    int cnt;

    initial begin
        nrst = 1'b0; wr_valid = 1'b0; wr_idx = '0; wr_rgb = '0; clr_req = 1'b0; commit = 1'b0;
        s_wr_valid = 1'b0; s_wr_idx = '0; s_wr_rgb = '0; s_clr_req = 1'b0; s_commit = 1'b0;
        repeat (3) tick();
        check("rst_framebuf", framebuf, 384'd0);
        check("rst_frame_count", frame_count, 0);
        check("rst_wr_ready", wr_ready, 0);
        check("rst_busy", busy, 0);
        check("rst_idx_err", idx_err, 0);
        nrst = 1'b1;
        tick();
        check("idle_wr_ready", wr_ready, 1);

        // Single pixel write then commit
        wr_valid = 1'b1; wr_idx = 4'd3; wr_rgb = 24'h112233;
        tick();
        wr_valid = 1'b0; commit = 1'b1;
        tick();
        commit = 1'b0;
        check("commit_pending_busy", busy, 1);
        check("fb_before_commit_exec", framebuf[95:72], 24'h000000);
        tick();
        check("led3_grb", framebuf[95:72], 24'h331122);
        check("count_after_1st", frame_count, 1);
        check("busy_after_commit", busy, 0);

        // Fill with commit on the same cycle
        clr_req = 1'b1; commit = 1'b1; wr_rgb = 24'hFF0000;
        #1;
        check("wr_ready_low_on_clr", wr_ready, 0);
        tick();
        clr_req = 1'b0; commit = 1'b0;
        cnt = 0;
        while (busy && cnt < 40) begin
            cnt++;
            tick();
        end
        check("fill_busy_cycles", cnt, 17);
        for (int i = 0; i < 16; i++) check($sformatf("fill_led%0d", i), framebuf[24*i +: 24], 24'h00FF00);
        check("count_after_fill", frame_count, 2);

        // Write in commit cycle is included, write one cycle later is not
        wr_valid = 1'b1; wr_idx = 4'd5; wr_rgb = 24'h0000AA; commit = 1'b1;
        tick();
        commit = 1'b0; wr_idx = 4'd6; wr_rgb = 24'h00BB00;
        tick();
        wr_valid = 1'b0;
        check("led5_in_frame", framebuf[24*5 +: 24], 24'hAA0000);
        check("led6_not_in_frame", framebuf[24*6 +: 24], 24'h00FF00);
        check("count_3", frame_count, 3);
        commit = 1'b1;
        tick();
        commit = 1'b0;
        tick();
        check("led6_next_frame", framebuf[24*6 +: 24], 24'h0000BB);
        check("count_4", frame_count, 4);

        // Framebuf holds without a commit
        wr_valid = 1'b1; wr_idx = 4'd0; wr_rgb = 24'h010101;
        repeat (3) tick();
        wr_valid = 1'b0;
        check("fb_stable_no_commit", framebuf[23:0], 24'h00FF00);

        // Back-to-back commits merge into one frame
        commit = 1'b1;
        tick();
        tick();
        commit = 1'b0;
        tick();
        check("merged_commits_count", frame_count, 5);
        check("led0_after_merge", framebuf[23:0], 24'h010101);

`ifdef NEOPIXEL_BRIGHTNESS_EN
        brightness = 8'd127;
        wr_valid = 1'b1; wr_idx = 4'd1; wr_rgb = 24'hFF8002; commit = 1'b1;
        tick();
        wr_valid = 1'b0; commit = 1'b0; brightness = 8'd255;
        tick();
        check("brightness_127", framebuf[47:24], 24'h017F40);
`endif

        // Out-of-range index on the 8-LED instance
        s_wr_valid = 1'b1; s_wr_idx = 4'd15; s_wr_rgb = 24'h123456;
        tick();
        check("idx_err_set", s_idx_err, 1);
        s_wr_idx = 4'd0; s_wr_rgb = 24'h010203;
        tick();
        s_wr_valid = 1'b0; s_commit = 1'b1;
        tick();
        s_commit = 1'b0;
        tick();
        check("idx_err_sticky", s_idx_err, 1);
        check("oob_write_dropped", s_framebuf, {168'd0, 24'h030102});

        nrst = 1'b0;
        tick();
        check("idx_err_cleared_by_reset", s_idx_err, 0);
        check("count_cleared_by_reset", frame_count, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
